// File: rtl/reg_alu_pkg.sv
// -----------------------------------------------------------------------------
// reg_alu_pkg
// Shared types for the register-file + ALU datapath: the 3-bit ALU opcode
// enumeration, the NZCV flag bundle and the default datapath dimensions.
// -----------------------------------------------------------------------------
package reg_alu_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/reg_file_alu_pipe_if.sv
// -----------------------------------------------------------------------------
// reg_file_alu_pipe_if
// Instruction-in / result-out bus of reg_file_alu_pipe.
//   in_valid/in_ready       instruction handshake (master -> slave)
//   RA1, RA2, WA            source / destination register addresses
//   write_enable, ALUSrc    write-back enable, immediate select
//   ALUControl, immediate   opcode and immediate operand
//   out_valid/out_ready     result handshake (slave -> master)
//   ALUResult, Zero, Negative, Carry, Overflow   registered result and flags
//   cpu_out                 contents of the designated output register
// The slave modport is the datapath; the master modport is the decoder/consumer.
// -----------------------------------------------------------------------------
interface reg_file_alu_pipe_if
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [ADDR_W-1:0] WA;
  logic              write_enable;
  logic              ALUSrc;
  alu_op_e           ALUControl;
  logic [DATA_W-1:0] immediate;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ALUResult;
  logic              Zero;
  logic              Negative;
  logic              Carry;
  logic              Overflow;
  logic [DATA_W-1:0] cpu_out;

  modport master (
    output in_valid, RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow, cpu_out
  );

  modport slave (
    input  in_valid, RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow, cpu_out
  );

endinterface

// File: rtl/reg_alu_core.sv
// -----------------------------------------------------------------------------
// reg_alu_core
// Purely combinational ALU: evaluates one of eight operations on two DATA_W-bit
// operands and produces the result with its NZCV flags.
//   i_a, i_b   operands (i_b already muxed between register and immediate)
//   i_op       operation select
//   o_result   DATA_W-bit wrapped result
//   o_flags    {z, n, c, v}; c/v meaningful for ADD, SUB and SLT only
// -----------------------------------------------------------------------------
module reg_alu_core
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output alu_flags_t        o_flags
);

  localparam int MSB  = DATA_W - 1;
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic              w_add_v;
  logic              w_sub_v;
  logic              w_lt;
  logic [SH_W-1:0]   w_shamt;

  // One extra bit captures the add carry-out and the subtract borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  assign w_add_v = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
  assign w_sub_v = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
  // Signed less-than: sign of the difference, corrected when it overflowed.
  assign w_lt    = w_diff[MSB] ^ w_sub_v;

  assign w_shamt = i_b[SH_W-1:0];

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    o_result  = '0;
    o_flags.c = 1'b0;
    o_flags.v = 1'b0;
    unique case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_ADD: begin
        o_result  = w_sum[MSB:0];
        o_flags.c = w_sum[DATA_W];
        o_flags.v = w_add_v;
      end
      ALU_SUB: begin
        o_result  = w_diff[MSB:0];
        o_flags.c = ~w_diff[DATA_W];
        o_flags.v = w_sub_v;
      end
      ALU_SLT: begin
        o_result  = {{(DATA_W-1){1'b0}}, w_lt};
        o_flags.c = ~w_diff[DATA_W];
        o_flags.v = w_sub_v;
      end
      ALU_SHL: o_result = i_a << w_shamt;
      ALU_SHR: o_result = i_a >> w_shamt;
      default: o_result = '0;
    endcase
    o_flags.z = (o_result == '0);
    o_flags.n = o_result[MSB];
  end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// -----------------------------------------------------------------------------
// reg_file_alu_pipe
// Register file + ALU with a single registered result stage.
//   CLK, nRST   clock (rising edge) and asynchronous active-low reset
//   io_bus      slave side of reg_file_alu_pipe_if (instruction in, result out)
// An instruction is accepted on in_valid && in_ready, its result is held in the
// output stage until out_valid && out_ready (retire), and on retire it is
// written back to WA when write_enable is set and WA is not R0. Operands that
// name the pending destination are forwarded from the output stage.
// -----------------------------------------------------------------------------
module reg_file_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int OUT_REG = (2**ADDR_W) - 1
) (
  input logic                CLK,
  input logic                nRST,
  reg_file_alu_pipe_if.slave io_bus
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_IDX  = ADDR_W'(OUT_REG);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  alu_flags_t        r_flags;
  logic [ADDR_W-1:0] r_wa;
  logic              r_wen;

  logic              w_accept;
  logic              w_retire;
  logic              w_fwd_live;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_result;
  alu_flags_t        w_alu_flags;

  // The stage frees up in the same cycle its contents are taken.
  assign io_bus.in_ready = !r_valid || io_bus.out_ready;
  assign w_accept        = io_bus.in_valid && io_bus.in_ready;
  assign w_retire        = r_valid && io_bus.out_ready;

  // A pending result is forwarded whether or not it retires this edge, so the
  // array read never needs to see the write of the same cycle.
  assign w_fwd_live = r_valid && r_wen;

  always_comb begin
    w_rd1 = r_regs[io_bus.RA1];
    if (io_bus.RA1 == '0)                          w_rd1 = '0;
    else if (w_fwd_live && (r_wa == io_bus.RA1))   w_rd1 = r_result;
  end

  always_comb begin
    w_rd2 = r_regs[io_bus.RA2];
    if (io_bus.RA2 == '0)                          w_rd2 = '0;
    else if (w_fwd_live && (r_wa == io_bus.RA2))   w_rd2 = r_result;
  end

  assign w_src_b = io_bus.ALUSrc ? io_bus.immediate : w_rd2;

  reg_alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i_a      (w_rd1),
    .i_b      (w_src_b),
    .i_op     (io_bus.ALUControl),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_wa     <= '0;
      r_wen    <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_alu_result;
      r_flags  <= w_alu_flags;
      r_wa     <= io_bus.WA;
      r_wen    <= io_bus.write_enable;
    end else if (w_retire) begin
      r_valid  <= 1'b0;
    end
  end

  // NOTE: the register array is architecturally visible state that must read
  // zero after reset, so it is reset along with the control flops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_regs <= '{default: '0};
    end else if (w_retire && r_wen && (r_wa != '0)) begin
      r_regs[r_wa] <= r_result;
    end
  end

  assign io_bus.out_valid = r_valid;
  assign io_bus.ALUResult = r_result;
  assign io_bus.Zero      = r_flags.z;
  assign io_bus.Negative  = r_flags.n;
  assign io_bus.Carry     = r_flags.c;
  assign io_bus.Overflow  = r_flags.v;
  assign io_bus.cpu_out   = r_regs[OUT_IDX];

endmodule
